asteroid_controller: RTL and testbench

- Upstream object engine for color_mapper; owns the obj_num asteroid slots and drives Obj_X/Obj_Y/Obj_Size/Obj_act.
- Once per video frame it walks the slots sequentially, one per Clk:
  - checks bullet and ship collisions;
  - moves active asteroids down;
  - retires off-screen or shot asteroids;
  - spawns new asteroids from an LFSR.
- Reports bullet hits, ship hit and score to the game state machine.

---
 rtl/asteroid_controller.sv | 181 ++++++++++++++++++
 tb/tb_asteroid_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_controller.sv
// Asteroid object engine: walks every slot once per frame to collide, move, retire and spawn,
// and reports hits, ship collision and score to the game state machine.
module asteroid_controller #(
    parameter int          obj_num      = 4,
    parameter int          SPEED        = 2,
    parameter int          SPAWN_PERIOD = 30,
    parameter int          SCREEN_H     = 480,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    game_screen,
    input  logic                    clear,
    input  logic [9:0]              ship_x,
    input  logic [9:0]              ship_y,
    input  logic [9:0]              bullet_x,
    input  logic [9:0]              bullet_y,
    input  logic [9:0]              bullet_size,
    input  logic                    bullet_activate,
    output logic [obj_num*10-1:0]   Obj_X,
    output logic [obj_num*10-1:0]   Obj_Y,
    output logic [obj_num*10-1:0]   Obj_Size,
    output logic [obj_num-1:0]      Obj_act,
    output logic                    bullet_hit,
    output logic                    ship_hit,
    output logic [15:0]             score
);
    localparam int IW = (obj_num > 1) ? $clog2(obj_num) : 1;

    typedef enum logic [1:0] {IDLE, UPDATE, SPAWN, DONE} state_t;
    state_t state_q, state_d;

    logic [9:0]    x_q [obj_num];
    logic [9:0]    y_q [obj_num];
    logic [9:0]    s_q [obj_num];
    logic [obj_num-1:0] act_q;
    logic [IW-1:0] idx_q;
    logic [15:0]   score_q, lfsr_q, timer_q;
    logic          ship_hit_q, hit_flag_q;
    logic          fc_meta_q, fc_sync_q, fc_prev_q, tick_q;

    // frame_clk is asynchronous: two-flop synchronizer, then a registered rising-edge pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_meta_q <= 1'b0;
            fc_sync_q <= 1'b0;
            fc_prev_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            fc_meta_q <= frame_clk;
            fc_sync_q <= fc_meta_q;
            fc_prev_q <= fc_sync_q;
            tick_q    <= fc_sync_q & ~fc_prev_q;
        end
    end

    // Current-slot view; boxes compared as a1 <= b2 && b1 <= a2, rearranged to avoid negatives
    logic [11:0] ax, ay, asz, bx, by, bs, sx, sy;
    logic        bullet_ovl, ship_ovl, off_screen;
    assign ax  = {2'b00, x_q[idx_q]};
    assign ay  = {2'b00, y_q[idx_q]};
    assign asz = {2'b00, s_q[idx_q]};
    assign bx  = {2'b00, bullet_x};
    assign by  = {2'b00, bullet_y};
    assign bs  = {2'b00, bullet_size};
    assign sx  = {2'b00, ship_x};
    assign sy  = {2'b00, ship_y};

    assign bullet_ovl = bullet_activate
                      && (bx < ax + asz + bs) && (ax <= bx + bs)
                      && (by < ay + asz + bs) && (ay <= by + bs);
    assign ship_ovl   = (sx < ax + asz + 12'd17) && (ax <= sx + 12'd17)
                      && (sy < ay + asz + 12'd16) && (ay <= sy + 12'd16);
    assign off_screen = (ay + 12'(SPEED)) >= 12'(SCREEN_H);

    logic          free_found;
    logic [IW-1:0] free_idx;
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = obj_num - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    logic [15:0] timer_dec, lfsr_step;
    logic        spawn_now;
    assign timer_dec = timer_q - 16'd1;
    assign spawn_now = (timer_dec == 16'd0);
    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)      state_q <= IDLE;
        else if (clear) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_q && game_screen) state_d = UPDATE;
            UPDATE:  if (idx_q == IW'(obj_num - 1)) state_d = SPAWN;
            SPAWN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bullet_hit = (state_q == DONE) && hit_flag_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < obj_num; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                s_q[i] <= '0;
            end
            act_q      <= '0;
            idx_q      <= '0;
            score_q    <= '0;
            ship_hit_q <= 1'b0;
            hit_flag_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            timer_q    <= 16'(SPAWN_PERIOD);
        end else if (clear) begin
            act_q      <= '0;
            score_q    <= '0;
            ship_hit_q <= 1'b0;
            hit_flag_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            timer_q    <= 16'(SPAWN_PERIOD);
        end else begin
            case (state_q)
                IDLE: idx_q <= '0;
                UPDATE: begin
                    if (act_q[idx_q]) begin
                        if (bullet_ovl) begin
                            act_q[idx_q] <= 1'b0;
                            hit_flag_q   <= 1'b1;
                            if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
                        end else begin
                            if (ship_ovl) ship_hit_q <= 1'b1;
                            if (off_screen) act_q[idx_q] <= 1'b0;
                            else            y_q[idx_q]   <= y_q[idx_q] + 10'(SPEED);
                        end
                    end
                    idx_q <= idx_q + 1'b1;
                end
                SPAWN: begin
                    timer_q <= spawn_now ? 16'(SPAWN_PERIOD) : timer_dec;
                    if (spawn_now && free_found) begin
                        act_q[free_idx] <= 1'b1;
                        y_q[free_idx]   <= '0;
                        x_q[free_idx]   <= {1'b0, lfsr_q[8:0]} + 10'd64;
                        s_q[free_idx]   <= 10'd16 + {5'b0, lfsr_q[10:9], 3'b000};
                    end
                    lfsr_q <= lfsr_step;
                end
                default: hit_flag_q <= 1'b0;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < obj_num; gi++) begin : g_pack
            assign Obj_X[gi*10 +: 10]    = x_q[gi];
            assign Obj_Y[gi*10 +: 10]    = y_q[gi];
            assign Obj_Size[gi*10 +: 10] = s_q[gi];
        end
    endgenerate

    assign Obj_act  = act_q;
    assign ship_hit = ship_hit_q;
    assign score    = score_q;
endmodule

// File: tb/tb_asteroid_controller.sv
// Randomized game frames against a slot-level reference model; a monitor scores each frame result.
module tb_asteroid_controller;
    localparam int N = 4;

    logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, game_screen = 1'b0, clear = 1'b0;
    logic [9:0] ship_x = 10'd950, ship_y = 10'd950;
    logic [9:0] bullet_x = '0, bullet_y = '0, bullet_size = '0;
    logic bullet_activate = 1'b0;
    logic [N*10-1:0] Obj_X, Obj_Y, Obj_Size;
    logic [N-1:0] Obj_act;
    logic bullet_hit, ship_hit;
    logic [15:0] score;

    asteroid_controller #(.obj_num(N)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_screen(game_screen), .clear(clear),
        .ship_x(ship_x), .ship_y(ship_y), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_size(bullet_size), .bullet_activate(bullet_activate),
        .Obj_X(Obj_X), .Obj_Y(Obj_Y), .Obj_Size(Obj_Size), .Obj_act(Obj_act),
        .bullet_hit(bullet_hit), .ship_hit(ship_hit), .score(score));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Reference game state: one entry per slot, plain integers
    int mx[N], my[N], ms[N];
    bit mact[N];
    int mscore, mtimer;
    bit mship;
    logic [15:0] mlfsr;

    typedef struct {
        int base;
        logic [N*10-1:0] ex, ey, es;
        logic [N-1:0] act;
        logic [15:0] sc;
        logic ship;
        logic hit;
    } exp_t;
    exp_t sb[$];

    function automatic bit ovl(int a1, int a2, int b1, int b2);
        return (a1 <= b2) && (b1 <= a2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; ms[i] = 0; mact[i] = 0;
        end
        mscore = 0; mship = 0; mlfsr = 16'hACE1; mtimer = 30;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mact[i] = 0;
        mscore = 0; mship = 0; mlfsr = 16'hACE1; mtimer = 30;
    endtask

    task automatic model_frame(output bit hit);
        int bx, by, bs, sx, sy, free;
        bx = int'(bullet_x); by = int'(bullet_y); bs = int'(bullet_size);
        sx = int'(ship_x);   sy = int'(ship_y);
        hit = 0;
        for (int i = 0; i < N; i++) begin
            if (!mact[i]) continue;
            if (bullet_activate && ovl(bx - bs, bx + bs, mx[i], mx[i] + ms[i] - 1)
                                && ovl(by - bs, by + bs, my[i], my[i] + ms[i] - 1)) begin
                mact[i] = 0;
                if (mscore < 65535) mscore++;
                hit = 1;
            end else begin
                if (ovl(sx - 17, sx + 17, mx[i], mx[i] + ms[i] - 1) &&
                    ovl(sy - 16, sy + 16, my[i], my[i] + ms[i] - 1)) mship = 1;
                if (my[i] + 2 >= 480) mact[i] = 0;
                else my[i] += 2;
            end
        end
        mtimer--;
        if (mtimer == 0) begin
            mtimer = 30;
            free = -1;
            for (int i = N - 1; i >= 0; i--) if (!mact[i]) free = i;
            if (free >= 0) begin
                mact[free] = 1;
                my[free] = 0;
                mx[free] = (int'(mlfsr) % 512) + 64;
                ms[free] = 16 + 8 * ((int'(mlfsr) / 512) % 4);
            end
        end
        mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    endtask

    function automatic exp_t snap(int base, bit hit);
        exp_t e;
        e.base = base;
        for (int i = 0; i < N; i++) begin
            e.ex[i*10 +: 10] = 10'(mx[i]);
            e.ey[i*10 +: 10] = 10'(my[i]);
            e.es[i*10 +: 10] = 10'(ms[i]);
            e.act[i] = mact[i];
        end
        e.sc = 16'(mscore);
        e.ship = mship;
        e.hit = hit;
        return e;
    endfunction

    function automatic logic [9:0] clamp10(int v);
        if (v < 0) return 10'd0;
        if (v > 1023) return 10'd1023;
        return 10'(v);
    endfunction

    task automatic randomize_inputs();
        int t;
        t = int'($urandom_range(0, N - 1));
        bullet_activate = ($urandom_range(0, 5) == 0);
        bullet_x    = clamp10(mx[t] + int'($urandom_range(0, 60)) - 20);
        bullet_y    = clamp10(my[t] + int'($urandom_range(0, 60)) - 20);
        bullet_size = 10'($urandom_range(0, 10));
        if ($urandom_range(0, 11) == 0) begin
            ship_x = clamp10(mx[t] + int'($urandom_range(0, 50)) - 15);
            ship_y = clamp10(my[t] + int'($urandom_range(0, 50)) - 15);
        end else begin
            ship_x = 10'(900 + $urandom_range(0, 100));
            ship_y = 10'(900 + $urandom_range(0, 100));
        end
    endtask

    // Called on a negedge with the DUT idle; the frame result must appear N+2 Clk after the tick
    task automatic do_frame(input bit gs, input bit extra);
        int k;
        bit hit;
        randomize_inputs();
        game_screen = gs;
        hit = 0;
        if (gs) model_frame(hit);
        k = cyc;
        sb.push_back(snap(k, hit));
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        if (extra) begin
            // this rise ticks while the FSM is busy and must be ignored
            while (cyc < k + 5) @(negedge Clk);
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
        end
        while (cyc < k + N + 10) @(negedge Clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, Obj_X, 0);
        chk({tag, "_y"}, Obj_Y, 0);
        chk({tag, "_size"}, Obj_Size, 0);
        chk({tag, "_act"}, Obj_act, 0);
        chk({tag, "_bhit"}, bullet_hit, 0);
        chk({tag, "_ship"}, ship_hit, 0);
        chk({tag, "_score"}, score, 0);
    endtask

    // Monitor: pops the next expected frame and compares around the DONE cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                while (cyc < e.base + N + 4) @(negedge Clk);
                chk("bhit_before", bullet_hit, 0);
                @(negedge Clk);
                chk("obj_x", Obj_X, e.ex);
                chk("obj_y", Obj_Y, e.ey);
                chk("obj_size", Obj_Size, e.es);
                chk("obj_act", Obj_act, e.act);
                chk("score", score, e.sc);
                chk("ship_hit", ship_hit, e.ship);
                chk("bullet_hit", bullet_hit, e.hit);
                $display("frame @%0d act=%b score=%0d ship=%0b bhit=%0b y=%h",
                         e.base, e.act, e.sc, e.ship, e.hit, e.ey);
                @(negedge Clk);
                chk("bhit_after", bullet_hit, 0);
            end
        end
    end

    initial begin
        int k;
        model_reset();
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        Reset = 1'b0;

        for (int f = 0; f < 400; f++) begin
            if (f == 330 || (f > 330 && $urandom_range(0, 49) == 0)) begin
                clear = 1'b1;
                @(negedge Clk);
                clear = 1'b0;
                model_clear();
            end
            do_frame((f < 30) ? 1'b1 : ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset in the middle of the slot walk
        randomize_inputs();
        game_screen = 1'b1;
        k = cyc;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        while (cyc < k + 6) @(negedge Clk);
        #2 Reset = 1'b1;
        #1 chk_all_zero("midreset");
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();

        for (int f = 0; f < 40; f++) do_frame(1'b1, 1'b0);

        repeat (4) @(negedge Clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
